// File: rtl/fp_exp_align_seq_if.sv
// Operand/result bundle for the exponent compare-and-align stage.
// master drives operands and out_ready; slave returns the ordered, aligned result.
interface fp_exp_align_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                     in_valid;
  logic                     in_ready;
  logic [EXP_W+MAN_W:0]     a;
  logic [EXP_W+MAN_W:0]     b;
  logic                     out_valid;
  logic                     out_ready;
  logic                     exp_neq;
  logic                     a_ge_b;
  logic                     special;
  logic                     sign_big;
  logic                     sign_small;
  logic [EXP_W-1:0]         exp_max;
  logic [EXP_W-1:0]         exp_diff;
  logic [MAN_W+3:0]         man_big;
  logic [MAN_W+3:0]         man_small;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, exp_neq, a_ge_b, special, sign_big, sign_small,
           exp_max, exp_diff, man_big, man_small
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, exp_neq, a_ge_b, special, sign_big, sign_small,
           exp_max, exp_diff, man_big, man_small
  );
endinterface

// File: rtl/fp_exp_align_seq.sv
// Orders two FP operands by magnitude and right-aligns the small mantissa with sticky, SHIFT_PER_CYC bits/cycle.
// Latency 1 + ceil(min(diff,MAN_W+4)/SHIFT_PER_CYC); one operation in flight, result held until out_ready.
module fp_exp_align_seq #(
  parameter int EXP_W         = 8,
  parameter int MAN_W         = 23,
  parameter int SHIFT_PER_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_exp_align_seq_if.slave   bus
);

  localparam int MW = MAN_W + 4;
  localparam int RW = $clog2(MW + 1);
  localparam logic [RW-1:0] SPC_R   = RW'(SHIFT_PER_CYC);
  localparam logic [RW-1:0] CLAMP_R = RW'(MW);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  logic              in_ready_c, out_valid_c, accept;
  logic              sign_a, sign_b, ge;
  logic [EXP_W-1:0]  exp_a, exp_b, eexp_a, eexp_b, diff;
  logic [MAN_W-1:0]  man_a, man_b;
  logic [MW-1:0]     mant_a, mant_b;
  logic [31:0]       diff_ext;
  logic [RW-1:0]     rem_init, step;
  logic [MW-1:0]     shifted, man_step;
  logic              lost;

  logic              exp_neq_q, a_ge_b_q, special_q, sign_big_q, sign_small_q;
  logic [EXP_W-1:0]  exp_max_q, exp_diff_q;
  logic [MW-1:0]     man_big_q, man_small_q;
  logic [RW-1:0]     remaining;

  assign sign_a = bus.a[EXP_W+MAN_W];
  assign sign_b = bus.b[EXP_W+MAN_W];
  assign exp_a  = bus.a[EXP_W+MAN_W-1:MAN_W];
  assign exp_b  = bus.b[EXP_W+MAN_W-1:MAN_W];
  assign man_a  = bus.a[MAN_W-1:0];
  assign man_b  = bus.b[MAN_W-1:0];

  // Denormals share the exponent of the smallest normal, without the hidden bit.
  assign eexp_a = (|exp_a) ? exp_a : EXP_W'(1);
  assign eexp_b = (|exp_b) ? exp_b : EXP_W'(1);
  assign mant_a = {|exp_a, man_a, 3'b000};
  assign mant_b = {|exp_b, man_b, 3'b000};

  assign ge       = (eexp_a > eexp_b) || ((eexp_a == eexp_b) && (man_a >= man_b));
  assign diff     = ge ? (eexp_a - eexp_b) : (eexp_b - eexp_a);
  assign diff_ext = 32'(diff);
  assign rem_init = (diff_ext > 32'(MW)) ? CLAMP_R : RW'(diff_ext);

  // Every bit shifted out, including the old LSB that already carries sticky, folds into the new LSB.
  assign step     = (remaining > SPC_R) ? SPC_R : remaining;
  assign shifted  = man_small_q >> step;
  assign lost     = |(man_small_q & ~({MW{1'b1}} << step));
  assign man_step = {shifted[MW-1:1], shifted[0] | lost};

  assign accept = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = (rem_init != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (remaining == step) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_neq_q    <= 1'b0;
      a_ge_b_q     <= 1'b0;
      special_q    <= 1'b0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      exp_max_q    <= '0;
      exp_diff_q   <= '0;
      man_big_q    <= '0;
      man_small_q  <= '0;
      remaining    <= '0;
    end else if (accept) begin
      exp_neq_q    <= (exp_a != exp_b);
      a_ge_b_q     <= ge;
      special_q    <= (&exp_a) || (&exp_b);
      sign_big_q   <= ge ? sign_a : sign_b;
      sign_small_q <= ge ? sign_b : sign_a;
      exp_max_q    <= ge ? eexp_a : eexp_b;
      exp_diff_q   <= diff;
      man_big_q    <= ge ? mant_a : mant_b;
      man_small_q  <= ge ? mant_b : mant_a;
      remaining    <= rem_init;
    end else if (state == SHIFT) begin
      man_small_q  <= man_step;
      remaining    <= remaining - step;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.exp_neq    = exp_neq_q;
  assign bus.a_ge_b     = a_ge_b_q;
  assign bus.special    = special_q;
  assign bus.sign_big   = sign_big_q;
  assign bus.sign_small = sign_small_q;
  assign bus.exp_max    = exp_max_q;
  assign bus.exp_diff   = exp_diff_q;
  assign bus.man_big    = man_big_q;
  assign bus.man_small  = man_small_q;

endmodule

// File: tb/tb_fp_exp_align_seq.sv
// Directed bench for fp_exp_align_seq with hand-computed single-precision vectors.
module tb_fp_exp_align_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  fp_exp_align_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_exp_align_seq #(.EXP_W(8), .MAN_W(23), .SHIFT_PER_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue one operation, check latency and result, optionally stall out_ready for 'hold' cycles, then handshake.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv, input int lat,
                       input logic ge, input logic neq, input logic sp, input logic sb, input logic ss,
                       input logic [7:0] emax, input logic [7:0] ediff,
                       input logic [26:0] mb, input logic [26:0] ms, input int hold);
    int cyc;
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      cyc++;
    end while (!bus.out_valid && cyc < 40);
    chk({tag, ".latency"},    64'(cyc),            64'(lat));
    chk({tag, ".a_ge_b"},     64'(bus.a_ge_b),     64'(ge));
    chk({tag, ".exp_neq"},    64'(bus.exp_neq),    64'(neq));
    chk({tag, ".special"},    64'(bus.special),    64'(sp));
    chk({tag, ".sign_big"},   64'(bus.sign_big),   64'(sb));
    chk({tag, ".sign_small"}, 64'(bus.sign_small), 64'(ss));
    chk({tag, ".exp_max"},    64'(bus.exp_max),    64'(emax));
    chk({tag, ".exp_diff"},   64'(bus.exp_diff),   64'(ediff));
    chk({tag, ".man_big"},    64'(bus.man_big),    64'(mb));
    chk({tag, ".man_small"},  64'(bus.man_small),  64'(ms));
    for (int i = 0; i < hold; i++) begin
      bus.a = 32'h40000000;
      bus.b = 32'h3F800000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk({tag, ".hold_valid"},     64'(bus.out_valid), 64'(1));
      chk({tag, ".hold_in_ready"},  64'(bus.in_ready),  64'(0));
      chk({tag, ".hold_man_small"}, 64'(bus.man_small), 64'(ms));
      chk({tag, ".hold_exp_max"},   64'(bus.exp_max),   64'(emax));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".post_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, ".post_ready"}, 64'(bus.in_ready),  64'(1));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    @(negedge clk);
    chk("rst.in_ready",  64'(bus.in_ready),  64'(1));
    chk("rst.out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst.man_big",   64'(bus.man_big),   64'(0));
    chk("rst.man_small", 64'(bus.man_small), 64'(0));
    chk("rst.exp_diff",  64'(bus.exp_diff),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //    tag        a             b             lat ge neq sp sb ss emax   ediff  man_big       man_small    hold
    do_op("equal",   32'h3F800000, 32'h3F800000, 1,  1, 0,  0, 0, 0, 8'h7F, 8'h00, 27'h4000000, 27'h4000000, 0);
    do_op("diff3",   32'h3F800000, 32'h41200000, 2,  0, 1,  0, 0, 0, 8'h82, 8'h03, 27'h5000000, 27'h0800000, 0);
    do_op("diff23",  32'h4B000000, 32'h3F800001, 7,  1, 1,  0, 0, 0, 8'h96, 8'h17, 27'h4000000, 27'h0000009, 0);
    do_op("clamp",   32'h7E800000, 32'h3F800000, 8,  1, 1,  0, 0, 0, 8'hFD, 8'h7E, 27'h4000000, 27'h0000001, 0);
    do_op("clamp0",  32'h7E800000, 32'h00000000, 8,  1, 1,  0, 0, 0, 8'hFD, 8'hFC, 27'h4000000, 27'h0000000, 0);
    do_op("signs",   32'hC0000000, 32'h3FC00000, 2,  1, 1,  0, 1, 0, 8'h80, 8'h01, 27'h4000000, 27'h3000000, 0);
    do_op("mantie",  32'h3F800000, 32'hBFC00000, 1,  0, 0,  0, 1, 0, 8'h7F, 8'h00, 27'h6000000, 27'h4000000, 0);
    do_op("denorm",  32'h00000003, 32'h00000001, 1,  1, 0,  0, 0, 0, 8'h01, 8'h00, 27'h0000018, 27'h0000008, 0);
    do_op("special", 32'h3F800000, 32'hFF800000, 8,  0, 1,  1, 1, 0, 8'hFF, 8'h80, 27'h4000000, 27'h0000001, 0);
    do_op("stall",   32'h3F800000, 32'h41200000, 2,  0, 1,  0, 0, 0, 8'h82, 8'h03, 27'h5000000, 27'h0800000, 5);

    // Reset in the middle of a long shift discards the operation immediately.
    bus.a = 32'h4B000000;
    bus.b = 32'h3F800001;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.busy", 64'(bus.in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst.in_ready",  64'(bus.in_ready),  64'(1));
    chk("midrst.man_small", 64'(bus.man_small), 64'(0));
    chk("midrst.man_big",   64'(bus.man_big),   64'(0));
    chk("midrst.exp_max",   64'(bus.exp_max),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("after",   32'h4B000000, 32'h3F800001, 7,  1, 1,  0, 0, 0, 8'h96, 8'h17, 27'h4000000, 27'h0000009, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
